// File: rtl/ss_pkg.sv
// ss_pkg: shared types and constants for the scroll controller.
//   ss_char_t          5-bit display character code fed to ssdec
//   SS_SPACE/SS_EIGHT  blank and "8" character codes
//   ss_scroll_state_t  controller state; ST_BLINK exists only when
//                      SS_SCROLL_BLINK_EN is defined
package ss_pkg;

   typedef logic [4:0] ss_char_t;

   localparam ss_char_t SS_SPACE = 5'b11001;
   localparam ss_char_t SS_EIGHT = 5'b01000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOADED,
`ifdef SS_SCROLL_BLINK_EN
      ST_BLINK,
`endif
      ST_SCROLL
   } ss_scroll_state_t;

endpackage

// File: rtl/ss_scroll_ctrl_if.sv
// ss_scroll_ctrl_if: message-load handshake between the game FSM (master)
// and ss_scroll_ctrl (slave).
//   load_valid  message offered
//   load_ready  controller can accept a message
//   load_len    message length in characters
//   load_chars  character k at [5k+4:5k]; char 0 enters the display first
interface ss_scroll_ctrl_if #(
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic               load_valid;
   logic               load_ready;
   logic [LEN_W-1:0]   load_len;
   logic [MAX_LEN*5-1:0] load_chars;

   modport master (output load_valid, load_len, load_chars, input load_ready);
   modport slave  (input load_valid, load_len, load_chars, output load_ready);
endinterface

// File: rtl/ss_tick_gen.sv
// ss_tick_gen: free-running divider counting 0..TICK_DIV-1 with a
// synchronous clear; tick is high for the one cycle the count sits at
// TICK_DIV-1, after which it wraps to 0.
//   clk, rst  clock and synchronous active-high reset
//   clr       hold the count at 0
//   tick      one-cycle step strobe
module ss_tick_gen #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/ss_scroll_ctrl.sv
// ss_scroll_ctrl: scrolls a stored message of 5-bit character codes
// right-to-left across NUM_DIGITS seven-segment digits (digit 0 rightmost).
//   clk, rst    clock and synchronous active-high reset
//   load        message-load handshake (ss_scroll_ctrl_if.slave)
//   start/stop  begin / abort scrolling; loop sampled on an accepted start
//   busy        scroll in progress
//   done        one-cycle pulse when a pass completes
//   digit_code  code for digit i at [5i+4:5i]
//   digit_en    per-digit enable to ssdec
// Optional: define SS_SCROLL_BLINK_EN to blink "8888" for four tick periods
// at the end of every non-looping pass.
module ss_scroll_ctrl
   import ss_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned TICK_DIV   = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   ss_scroll_ctrl_if.slave         load,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_DIGITS*5-1:0] digit_code,
   output logic [NUM_DIGITS-1:0]   digit_en
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned POS_W = $clog2(MAX_LEN + NUM_DIGITS + 1);

   ss_scroll_state_t     state;
   logic [MAX_LEN*5-1:0] msg;
   logic [LEN_W-1:0]     len;
   logic [LEN_W-1:0]     len_in;
   logic [POS_W-1:0]     pos;
   logic [POS_W-1:0]     pos_inc;
   logic                 loop_q;
   logic                 tick;
   logic                 scrolling;
   logic                 load_acc;
   logic                 start_acc;
   logic                 pass_end;
   logic [NUM_DIGITS*5-1:0] frame_code;
   logic [NUM_DIGITS-1:0]   frame_en;
   int                   k_idx;
`ifdef SS_SCROLL_BLINK_EN
   logic [1:0]           blink_cnt;
`endif

`ifdef SS_SCROLL_BLINK_EN
   assign scrolling = (state == ST_SCROLL) || (state == ST_BLINK);
`else
   assign scrolling = (state == ST_SCROLL);
`endif

   assign load_acc  = load.load_valid && load.load_ready;
   // a load in the same cycle wins over start
   assign start_acc = start && (state == ST_LOADED) && !load_acc;
   assign len_in    = (load.load_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : load.load_len;
   assign pos_inc   = pos + POS_W'(1);
   assign pass_end  = (pos_inc == POS_W'(len) + POS_W'(NUM_DIGITS));

   ss_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (!scrolling),
      .tick (tick)
   );

   // Frame for the next step position: digit i shows char p-1-i when in range.
   always_comb begin
      frame_code = '0;
      frame_en   = '0;
      k_idx      = 0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         k_idx = int'(pos_inc) - 1 - int'(i);
         if (k_idx >= 0 && k_idx < int'(len)) begin
            frame_code[5*i +: 5] = msg[5*k_idx +: 5];
            frame_en[i]          = 1'b1;
         end else begin
            frame_code[5*i +: 5] = SS_SPACE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         msg             <= '0;
         len             <= '0;
         pos             <= '0;
         loop_q          <= 1'b0;
         load.load_ready <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         digit_code      <= {NUM_DIGITS{SS_SPACE}};
         digit_en        <= '0;
`ifdef SS_SCROLL_BLINK_EN
         blink_cnt       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_LOADED: begin
               if (load_acc) begin
                  msg   <= load.load_chars;
                  len   <= len_in;
                  state <= ST_LOADED;
               end else if (start_acc) begin
                  pos    <= '0;
                  loop_q <= loop;
                  if (len == '0) begin
                     // nothing to show: the pass is over immediately
                     done <= 1'b1;
                  end else begin
                     state           <= ST_SCROLL;
                     busy            <= 1'b1;
                     load.load_ready <= 1'b0;
                  end
               end
            end
            ST_SCROLL: begin
               if (stop) begin
                  state           <= ST_LOADED;
                  busy            <= 1'b0;
                  load.load_ready <= 1'b1;
                  digit_code      <= {NUM_DIGITS{SS_SPACE}};
                  digit_en        <= '0;
               end else if (tick) begin
                  if (!pass_end) begin
                     pos        <= pos_inc;
                     digit_code <= frame_code;
                     digit_en   <= frame_en;
                  end else if (loop_q) begin
                     pos        <= '0;
                     done       <= 1'b1;
                     digit_code <= {NUM_DIGITS{SS_SPACE}};
                     digit_en   <= '0;
                  end else begin
`ifdef SS_SCROLL_BLINK_EN
                     state      <= ST_BLINK;
                     blink_cnt  <= '0;
                     digit_code <= {NUM_DIGITS{SS_EIGHT}};
                     digit_en   <= '1;
`else
                     state           <= ST_LOADED;
                     busy            <= 1'b0;
                     load.load_ready <= 1'b1;
                     done            <= 1'b1;
                     digit_code      <= {NUM_DIGITS{SS_SPACE}};
                     digit_en        <= '0;
`endif
                  end
               end
            end
`ifdef SS_SCROLL_BLINK_EN
            ST_BLINK: begin
               if (stop || (tick && blink_cnt == 2'd3)) begin
                  state           <= ST_LOADED;
                  busy            <= 1'b0;
                  load.load_ready <= 1'b1;
                  done            <= !stop;
                  digit_code      <= {NUM_DIGITS{SS_SPACE}};
                  digit_en        <= '0;
               end else if (tick) begin
                  // even periods lit, odd periods dark
                  blink_cnt <= blink_cnt + 2'd1;
                  digit_en  <= blink_cnt[0] ? '1 : '0;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// tb_ss_scroll_ctrl: scoreboard bench for ss_scroll_ctrl with
// NUM_DIGITS=4, MAX_LEN=8, TICK_DIV=3. Expected samples are queued with the
// cycle they are due; expected done pulses are queued and popped as the
// DUT emits them. Define SS_SCROLL_BLINK_EN to bench the blink build.
module tb_ss_scroll_ctrl;
   localparam int unsigned ND = 4;
   localparam int unsigned ML = 8;
   localparam int unsigned TD = 3;
   localparam logic [4:0]  SP = 5'd25;
`ifdef SS_SCROLL_BLINK_EN
   localparam int BL = 12;
`else
   localparam int BL = 0;
`endif

   localparam int S_BUSY = 0, S_DONE = 1, S_EN = 2, S_CODE = 3, S_READY = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic busy, done;
   logic [ND*5-1:0] digit_code;
   logic [ND-1:0]   digit_en;

   ss_scroll_ctrl_if #(.MAX_LEN(ML)) lif ();

   ss_scroll_ctrl #(.NUM_DIGITS(ND), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (lif),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .busy       (busy),
      .done       (done),
      .digit_code (digit_code),
      .digit_en   (digit_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   done_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void expect_at(input int c, input int s, input logic [31:0] v, input string tag);
      exp_t e;
      e.cyc = c; e.sig = s; e.val = v; e.tag = tag;
      sb.push_back(e);
   endfunction

   function automatic logic [31:0] pk(input logic [4:0] c3, c2, c1, c0);
      return {12'd0, c3, c2, c1, c0};
   endfunction

   function automatic logic [31:0] sigval(input int s);
      case (s)
         S_BUSY:  return {31'd0, busy};
         S_DONE:  return {31'd0, done};
         S_EN:    return {28'd0, digit_en};
         S_CODE:  return {12'd0, digit_code};
         default: return {31'd0, lif.load_ready};
      endcase
   endfunction

   // sample monitor: compare every queued expectation that is due now
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) check_val({e.tag, "_late"}, cyc, e.cyc);
         else             check_val(e.tag, sigval(e.sig), e.val);
      end
   end

   // done monitor: each pulse must match the next expected done cycle
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (done_q.size() == 0) check_val("done_unexpected", cyc, 32'hffff_ffff);
         else                    check_val("done_cycle", cyc, done_q.pop_front());
      end
   end

   task automatic to_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [3:0] l, input logic [39:0] ch);
      lif.load_len   = l;
      lif.load_chars = ch;
      lif.load_valid = 1'b1;
      @(posedge clk); #1;
      lif.load_valid = 1'b0;
   endtask

   task automatic do_start(input logic lp, output int t);
      start = 1'b1;
      loop  = lp;
      t     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      loop  = 1'b0;
   endtask

   logic [39:0] hello = {15'd0, 5'd0, 5'd19, 5'd19, 5'd14, 5'd17};
   logic [39:0] ramp  = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
   logic [39:0] junk  = {8{5'd3}};

   initial begin
      int t, c;
      lif.load_valid = 1'b0;
      lif.load_len   = '0;
      lif.load_chars = '0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", {31'd0, lif.load_ready}, 1);
      check_val("rst_busy",  {31'd0, busy}, 0);
      check_val("rst_done",  {31'd0, done}, 0);
      check_val("rst_en",    {28'd0, digit_en}, 0);
      check_val("rst_code",  {12'd0, digit_code}, pk(SP, SP, SP, SP));
      rst = 1'b0;
      @(posedge clk); #1;

      // start in IDLE is ignored
      do_start(1'b0, t);
      expect_at(t + 1, S_BUSY, 0, "idle_start_busy");
      expect_at(t + 2, S_EN, 0, "idle_start_en");
      to_cycle(t + 4);

      // HELLO, single pass
      do_load(4'd5, hello);
      expect_at(cyc, S_READY, 1, "loaded_ready");
      @(posedge clk); #1;
      do_start(1'b0, t);
      expect_at(t + 1, S_BUSY, 1, "p0_busy");
      expect_at(t + 1, S_READY, 0, "p0_ready");
      expect_at(t + 1, S_CODE, pk(SP, SP, SP, SP), "p0_code");
      expect_at(t + 3, S_EN, 0, "p0_en");
      expect_at(t + 4, S_EN, 4'b0001, "p1_en");
      expect_at(t + 4, S_CODE, pk(SP, SP, SP, 17), "p1_code");
      expect_at(t + 7, S_EN, 4'b0011, "p2_en");
      expect_at(t + 7, S_CODE, pk(SP, SP, 17, 14), "p2_code");
      expect_at(t + 16, S_EN, 4'b1111, "p5_en");
      expect_at(t + 16, S_CODE, pk(14, 19, 19, 0), "p5_code");
      expect_at(t + 25, S_EN, 4'b1000, "p8_en");
      expect_at(t + 25, S_CODE, pk(0, SP, SP, SP), "p8_code");
`ifdef SS_SCROLL_BLINK_EN
      for (int i = 28; i < 40; i++) begin
         expect_at(t + i, S_EN, (((i - 28) / 3) % 2 == 0) ? 32'hf : 32'h0, "blink_en");
         expect_at(t + i, S_CODE, pk(8, 8, 8, 8), "blink_code");
         expect_at(t + i, S_BUSY, 1, "blink_busy");
      end
`endif
      expect_at(t + 28 + BL, S_BUSY, 0, "end_busy");
      expect_at(t + 28 + BL, S_READY, 1, "end_ready");
      expect_at(t + 28 + BL, S_EN, 0, "end_en");
      done_q.push_back(t + 28 + BL);
      to_cycle(t + 32 + BL);

      // looping, load attempt while scrolling, then stop
      do_start(1'b1, t);
      expect_at(t + 1, S_BUSY, 1, "loop_busy0");
      expect_at(t + 6, S_READY, 0, "scroll_ready");
      expect_at(t + 16, S_CODE, pk(14, 19, 19, 0), "keep_code");
      expect_at(t + 28, S_BUSY, 1, "loop_busy1");
      expect_at(t + 55, S_BUSY, 1, "loop_busy2");
      expect_at(t + 59, S_EN, 4'b0001, "loop3_en");
      expect_at(t + 59, S_CODE, pk(SP, SP, SP, 17), "loop3_code");
      expect_at(t + 61, S_BUSY, 0, "stop_busy");
      expect_at(t + 61, S_EN, 0, "stop_en");
      expect_at(t + 61, S_READY, 1, "stop_ready");
      expect_at(t + 61, S_CODE, pk(SP, SP, SP, SP), "stop_code");
      done_q.push_back(t + 28);
      done_q.push_back(t + 55);
      to_cycle(t + 5);
      lif.load_len   = 4'd3;
      lif.load_chars = junk;
      lif.load_valid = 1'b1;
      to_cycle(t + 8);
      lif.load_valid = 1'b0;
      to_cycle(t + 60);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      to_cycle(t + 75);

      // length clamp: 12 is stored as 8
      do_load(4'd12, ramp);
      do_start(1'b0, t);
      expect_at(t + 34, S_EN, 4'b1000, "clamp_en");
      expect_at(t + 34, S_CODE, pk(8, SP, SP, SP), "clamp_code");
      expect_at(t + 37 + BL, S_BUSY, 0, "clamp_busy");
      done_q.push_back(t + 37 + BL);
      to_cycle(t + 40 + BL);

      // load and start together in LOADED: load wins
      lif.load_len   = 4'd0;
      lif.load_chars = '0;
      lif.load_valid = 1'b1;
      start          = 1'b1;
      c              = cyc;
      @(posedge clk); #1;
      lif.load_valid = 1'b0;
      start          = 1'b0;
      expect_at(c + 1, S_BUSY, 0, "both_busy1");
      expect_at(c + 1, S_READY, 1, "both_ready");
      expect_at(c + 2, S_BUSY, 0, "both_busy2");
      to_cycle(c + 4);

      // zero-length message
      do_start(1'b0, t);
      expect_at(t + 1, S_BUSY, 0, "len0_busy");
      expect_at(t + 1, S_EN, 0, "len0_en");
      expect_at(t + 2, S_DONE, 0, "len0_done_off");
      done_q.push_back(t + 1);
      to_cycle(t + 5);

      // reset mid-scroll, then start from IDLE is ignored
      do_load(4'd5, hello);
      do_start(1'b0, t);
      expect_at(t + 4, S_EN, 4'b0001, "pre_rst_en");
      expect_at(t + 11, S_BUSY, 0, "mid_rst_busy");
      expect_at(t + 11, S_EN, 0, "mid_rst_en");
      expect_at(t + 11, S_READY, 1, "mid_rst_ready");
      expect_at(t + 11, S_CODE, pk(SP, SP, SP, SP), "mid_rst_code");
      to_cycle(t + 10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      to_cycle(t + 13);
      do_start(1'b0, t);
      expect_at(t + 1, S_BUSY, 0, "post_rst_busy1");
      expect_at(t + 3, S_BUSY, 0, "post_rst_busy3");
      expect_at(t + 4, S_EN, 0, "post_rst_en");
      to_cycle(t + 8);

      check_val("sb_left", sb.size(), 0);
      check_val("done_missing", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ss_scroll_ctrl.md
# ss_scroll_ctrl

Sequencer that scrolls a stored message of 5-bit display character codes right-to-left across a bank of seven-segment digits. It drives one `ssdec` instance per digit with a character code and enable. The game FSM loads a message over a valid/ready handshake, then starts, stops or loops the scroll. It sits between the game logic and the per-digit decoders.

## Interface
Parameters:
- `NUM_DIGITS`, 8, number of physical digits; digit 0 is the rightmost.
- `MAX_LEN`, 16, maximum message length in characters.
- `TICK_DIV`, 1_000_000, clock cycles per scroll step (≥2).

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — synchronous, active-high reset.
- `load_valid` in 1 — message offered.
- `load_ready` out 1 — controller can accept a message.
- `load_len` in $clog2(MAX_LEN+1) — message length.
- `load_chars` in MAX_LEN*5 — character k is at bits [5k+4:5k]; char 0 enters the display first.
- `start` in 1 — begin scrolling the stored message.
- `stop` in 1 — abort scrolling.
- `loop` in 1 — repeat forever; sampled on an accepted start.
- `busy` out 1 — scroll in progress.
- `done` out 1 — one-cycle pulse when a pass completes.
- `digit_code` out NUM_DIGITS*5 — code for digit i at [5i+4:5i].
- `digit_en` out NUM_DIGITS — per-digit enable to `ssdec`.

## Operation
- States:
  - IDLE: no message stored.
  - LOADED: message stored, not scrolling.
  - SCROLL: scroll in progress.
  - BLINK: present only with the macro defined.
- Load:
  - Accepted when `load_valid && load_ready`.
  - `load_ready` = 1 in IDLE and LOADED, 0 otherwise.
  - Accepting a load stores the chars and length, then goes to LOADED.
  - `load_len` > MAX_LEN is clamped to MAX_LEN.
- Start:
  - Accepted only in LOADED, and only if no load is accepted in the same cycle (load wins).
  - Start in IDLE is ignored.
  - An accepted start clears the step position p to 0, clears the tick counter, latches `loop`, and goes to SCROLL.
- Frame at position p:
  - Digit i shows char index k = p−1−i if 0 ≤ k < len, with `digit_en[i]`=1.
  - Otherwise it shows code 5'b11001 (space) with `digit_en[i]`=0.
- Step:
  - The tick counter counts 0..TICK_DIV−1; at TICK_DIV−1 it wraps and p increments.
  - A pass ends when p reaches len+NUM_DIGITS, at which point the display is fully blank again.
- End of pass:
  - `done` pulses.
  - If loop is latched: p ← 0 and scrolling continues.
  - If not: go to LOADED. The stored message is retained, so start can replay it.
- `len` = 0: a start produces `done` one cycle after acceptance, then the block returns to LOADED.
- `stop` in SCROLL/BLINK:
  - Takes priority over a tick in the same cycle.
  - Next cycle: LOADED, outputs blanked, no `done`.
- `stop` in other states is ignored.
- Reset mid-scroll: immediate return to IDLE, and the message is discarded.

## Timing
- All outputs are registered.
- Reset values: `load_ready`=1, `busy`=0, `done`=0, `digit_en`=0, every `digit_code`=5'b11001.
- Start accepted at edge t:
  - `busy`=1 and frame p=0 from cycle t+1.
  - Frame p is visible from cycle t+1+p·TICK_DIV.
- Pass completion (no blink, no loop) at cycle t+1+(len+NUM_DIGITS)·TICK_DIV:
  - `done`=1 for that cycle.
  - `busy`=0 and `load_ready`=1 in the same cycle.
- Looping: `done` pulses each pass and `busy` stays 1.

## Configuration
- `SS_SCROLL_BLINK_EN` defined:
  - A non-looping pass enters BLINK instead of ending.
  - BLINK lasts 4 tick periods. Every digit shows code 5'b01000 (8), and `digit_en` is all-ones in periods 0 and 2 and all-zeros in periods 1 and 3.
  - `done` pulses on exit to LOADED.
  - `busy` stays 1 through BLINK.
  - Looping passes never blink.
- Undefined: the BLINK state and its logic are absent, and passes end as described in Operation.

## Structure
- Shared package `ss_pkg` holds:
  - `typedef logic [4:0] ss_char_t`.
  - Code constants `SS_SPACE`=5'b11001 and `SS_EIGHT`=5'b01000.
  - The state enum `ss_scroll_state_t`.
- Sub-module `ss_tick_gen` is natural: a parameterised TICK_DIV counter with synchronous clear, emitting a 1-cycle `tick`.
- The `ssdec` instances live in the parent, not in this block.

## Test plan
Bench config: NUM_DIGITS=4, MAX_LEN=8, TICK_DIV=3. The message "HELLO" uses codes 17,14,19,19,0.

- Load "HELLO" with len 5, start at t → at t+4 digit0=17 en=4'b0001; at t+7 digit1=17 and digit0=14, en=4'b0011; `done` at t+28 with `busy` dropping in the same cycle.
- Start with `loop`=1 → `done` at t+28 and t+55; `busy` stays 1; `stop` at t+60 → LOADED next cycle, all en=0, no further `done`.
- `load_valid` during SCROLL → `load_ready`=0 and message unchanged; `load_len`=12 → stored length 8.
- Load and start in the same cycle in LOADED → load accepted, start ignored, `busy` stays 0; start in IDLE → ignored.
- `len`=0 start → `done` at t+1, no digit enabled; `rst` mid-scroll → reset values next cycle, and a subsequent start is ignored (IDLE).
- With `SS_SCROLL_BLINK_EN`: "HELLO" → en toggles 1111/0000/1111/0000 with all codes 8 over t+28..t+39, then `done` at t+40.
